// File: rtl/voxel_mem_pkg.sv
// Shared definitions for the voxel_memory_64 write path.
//   VOX_ADDR_W / VOX_DATA_W : default voxel address ({x,y,z}, 6b each) and word widths
//   OWN_*                   : mem_owner encodings (0 = generator, 1+i = host port i)
//   S_*                     : write arbiter state encodings
package voxel_mem_pkg;

    localparam int unsigned VOX_ADDR_W = 18;
    localparam int unsigned VOX_DATA_W = 64;
    localparam int unsigned OWNER_W    = 3;
    localparam int unsigned STATE_W    = 2;

    localparam logic [OWNER_W-1:0] OWN_GEN   = 3'd0;
    localparam logic [OWNER_W-1:0] OWN_HOST0 = 3'd1;

    localparam logic [STATE_W-1:0] S_HOST = 2'd0;
    localparam logic [STATE_W-1:0] S_GEN  = 2'd1;
    localparam logic [STATE_W-1:0] S_HOLD = 2'd2;

    // Owner code for host port idx.
    function automatic logic [OWNER_W-1:0] host_owner(input logic [1:0] idx);
        return OWN_HOST0 + OWNER_W'(idx);
    endfunction

endpackage

// File: rtl/voxel_rr_pick.sv
// Rotating-priority picker: grants the first set valid bit searching upward
// from ptr_i, wrapping modulo N.
//   valid_i : request vector
//   ptr_i   : highest-priority index
//   grant_o : one-hot grant (all zero when nothing is valid)
//   idx_o   : binary index of the grant
//   any_o   : a grant was issued
module voxel_rr_pick #(
    parameter int unsigned N     = 2,
    parameter int unsigned IDX_W = 1
) (
    input  logic [N-1:0]     valid_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     grant_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    // Offset k walks the priority order; i finds the port sitting at that offset.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            for (int unsigned i = 0; i < N; i++) begin
                if (!any_o && (i == ((32'(ptr_i) + k) % N)) && valid_i[i]) begin
                    grant_o[i] = 1'b1;
                    idx_o      = IDX_W'(i);
                    any_o      = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/voxel_write_arbiter.sv
// Owns the voxel_memory_64 write port. The generator gets exclusive,
// unstallable access while busy; otherwise host ports are served round-robin.
//   clk, rst                     : clock, async active-high reset
//   gen_busy / gen_write_*       : generator level and fire-and-forget writes
//   req_valid/ready/addr/data    : host valid/ready ports, packed per port
//   mem_write_en/addr/data       : registered memory write, 1 cycle after acceptance
//   mem_owner                    : source of the current write
//   gen_active                   : generator phase (S_GEN or S_HOLD)
//   write_count                  : committed writes, wrapping
//   proto_err                    : sticky, gen_write_en seen with gen_busy low
module voxel_write_arbiter
    import voxel_mem_pkg::*;
#(
    parameter int unsigned NUM_PORTS   = 2,
    parameter int unsigned ADDR_W      = VOX_ADDR_W,
    parameter int unsigned DATA_W      = VOX_DATA_W,
    parameter int unsigned HOLD_CYCLES = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        gen_busy,
    input  logic                        gen_write_en,
    input  logic [ADDR_W-1:0]           gen_write_addr,
    input  logic [DATA_W-1:0]           gen_write_data,
    input  logic [NUM_PORTS-1:0]        req_valid,
    output logic [NUM_PORTS-1:0]        req_ready,
    input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
    input  logic [NUM_PORTS*DATA_W-1:0] req_data,
    output logic                        mem_write_en,
    output logic [ADDR_W-1:0]           mem_write_addr,
    output logic [DATA_W-1:0]           mem_write_data,
    output logic [OWNER_W-1:0]          mem_owner,
    output logic                        gen_active,
    output logic [31:0]                 write_count,
    output logic                        proto_err
);

    localparam int unsigned PTR_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int unsigned HOLD_W = 4;
    localparam logic [PTR_W-1:0] LAST_PORT = PTR_W'(NUM_PORTS - 1);

    logic [STATE_W-1:0] state_q, state_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic               wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]  wr_data_q, wr_data_d;
    logic [OWNER_W-1:0] owner_q, owner_d;
    logic [31:0]        count_q;
    logic               perr_q, perr_d;
    logic               gen_active_q;

    logic                 host_open;
    logic [NUM_PORTS-1:0] pick_valid;
    logic [NUM_PORTS-1:0] grant;
    logic [PTR_W-1:0]     grant_idx;
    logic                 grant_any;
    logic [ADDR_W-1:0]    host_addr;
    logic [DATA_W-1:0]    host_data;

    // Hosts compete only in S_HOST with the generator fully idle this cycle.
    assign host_open  = (state_q == S_HOST) && !gen_busy && !gen_write_en;
    assign pick_valid = host_open ? req_valid : '0;

    voxel_rr_pick #(
        .N     (NUM_PORTS),
        .IDX_W (PTR_W)
    ) u_pick (
        .valid_i (pick_valid),
        .ptr_i   (rr_ptr_q),
        .grant_o (grant),
        .idx_o   (grant_idx),
        .any_o   (grant_any)
    );

    assign req_ready = grant;

    // Payload of the granted host port.
    always_comb begin
        host_addr = '0;
        host_data = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (grant[i]) begin
                host_addr = req_addr[i*ADDR_W +: ADDR_W];
                host_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Next-state: arbitration FSM, write capture, round-robin pointer.
    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        rr_ptr_d  = rr_ptr_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        owner_d   = owner_q;
        perr_d    = perr_q | (gen_write_en & ~gen_busy);

        case (state_q)
            S_HOST: begin
                if (gen_busy) begin
                    state_d = S_GEN;
                end
            end
            S_GEN: begin
                if (!gen_busy) begin
                    if (HOLD_CYCLES == 0) begin
                        state_d = S_HOST;
                    end else begin
                        state_d = S_HOLD;
                        hold_d  = HOLD_W'(HOLD_CYCLES);
                    end
                end
            end
            S_HOLD: begin
                if (gen_busy) begin
                    state_d = S_GEN;
                    hold_d  = '0;
                end else if (hold_q <= HOLD_W'(1)) begin
                    state_d = S_HOST;
                    hold_d  = '0;
                end else begin
                    hold_d = hold_q - HOLD_W'(1);
                end
            end
            default: begin
                state_d = S_HOST;
                hold_d  = '0;
            end
        endcase

        // Generator writes always win; a host write needs a handshake.
        if (gen_write_en) begin
            wr_en_d   = 1'b1;
            wr_addr_d = gen_write_addr;
            wr_data_d = gen_write_data;
            owner_d   = OWN_GEN;
        end else if (grant_any) begin
            wr_en_d   = 1'b1;
            wr_addr_d = host_addr;
            wr_data_d = host_data;
            owner_d   = host_owner(2'(grant_idx));
            rr_ptr_d  = (grant_idx == LAST_PORT) ? '0 : grant_idx + PTR_W'(1);
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_HOST;
            hold_q       <= '0;
            rr_ptr_q     <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            owner_q      <= OWN_GEN;
            count_q      <= '0;
            perr_q       <= 1'b0;
            gen_active_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            rr_ptr_q     <= rr_ptr_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            owner_q      <= owner_d;
            count_q      <= count_q + 32'(wr_en_q);
            perr_q       <= perr_d;
            gen_active_q <= (state_d != S_HOST);
        end
    end

    assign mem_write_en   = wr_en_q;
    assign mem_write_addr = wr_addr_q;
    assign mem_write_data = wr_data_q;
    assign mem_owner      = owner_q;
    assign gen_active     = gen_active_q;
    assign write_count    = count_q;
    assign proto_err      = perr_q;

endmodule

// File: tb/tb_voxel_write_arbiter.sv
// Bench for voxel_write_arbiter: a 2-port / HOLD=2 instance checked against a
// cycle-level reference model, plus a 1-port / HOLD=0 instance with directed checks.
module tb_voxel_write_arbiter;
    import voxel_mem_pkg::*;

    localparam int unsigned NP   = 2;
    localparam int unsigned AW   = 18;
    localparam int unsigned DW   = 64;
    localparam int unsigned HOLD = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Main instance
    logic             gen_busy, gen_write_en;
    logic [AW-1:0]    gen_write_addr;
    logic [DW-1:0]    gen_write_data;
    logic [NP-1:0]    req_valid, req_ready;
    logic [NP*AW-1:0] req_addr;
    logic [NP*DW-1:0] req_data;
    logic             mem_write_en, gen_active, proto_err;
    logic [AW-1:0]    mem_write_addr;
    logic [DW-1:0]    mem_write_data;
    logic [2:0]       mem_owner;
    logic [31:0]      write_count;

    voxel_write_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .HOLD_CYCLES(HOLD)) dut (
        .clk(clk), .rst(rst),
        .gen_busy(gen_busy), .gen_write_en(gen_write_en),
        .gen_write_addr(gen_write_addr), .gen_write_data(gen_write_data),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data),
        .mem_write_en(mem_write_en), .mem_write_addr(mem_write_addr),
        .mem_write_data(mem_write_data), .mem_owner(mem_owner),
        .gen_active(gen_active), .write_count(write_count), .proto_err(proto_err)
    );

    // Single-port, zero-hold instance
    logic          b_busy, b_gwe;
    logic [AW-1:0] b_gaddr, b_addr, b_maddr;
    logic [DW-1:0] b_gdata, b_data, b_mdata;
    logic [0:0]    b_valid, b_ready;
    logic          b_men, b_gact, b_perr;
    logic [2:0]    b_owner;
    logic [31:0]   b_count;

    voxel_write_arbiter #(.NUM_PORTS(1), .ADDR_W(AW), .DATA_W(DW), .HOLD_CYCLES(0)) dut_b (
        .clk(clk), .rst(rst),
        .gen_busy(b_busy), .gen_write_en(b_gwe),
        .gen_write_addr(b_gaddr), .gen_write_data(b_gdata),
        .req_valid(b_valid), .req_ready(b_ready),
        .req_addr(b_addr), .req_data(b_data),
        .mem_write_en(b_men), .mem_write_addr(b_maddr),
        .mem_write_data(b_mdata), .mem_owner(b_owner),
        .gen_active(b_gact), .write_count(b_count), .proto_err(b_perr)
    );

    int vec  = 0;
    int errs = 0;

    // Reference model state
    int          cyc, last_busy, ptr, hs;
    logic        exp_en, exp_perr;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_data;
    logic [2:0]  exp_owner;
    logic [31:0] exp_cnt;

    // Host request holding registers
    logic          pv [NP];
    logic [AW-1:0] pa [NP];
    logic [DW-1:0] pd [NP];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_hosts();
        for (int p = 0; p < NP; p++) begin
            req_valid[p]            = pv[p];
            req_addr[p*AW +: AW]    = pa[p];
            req_data[p*DW +: DW]    = pd[p];
        end
    endtask

    task automatic new_req(input int p);
        pv[p] = 1'b1;
        pa[p] = AW'($urandom);
        pd[p] = {$urandom, $urandom};
    endtask

    task automatic idle_inputs();
        gen_busy = 0; gen_write_en = 0; gen_write_addr = '0; gen_write_data = '0;
        for (int p = 0; p < NP; p++) begin
            pv[p] = 0; pa[p] = '0; pd[p] = '0;
        end
        drive_hosts();
        b_busy = 0; b_gwe = 0; b_gaddr = '0; b_gdata = '0;
        b_valid = '0; b_addr = '0; b_data = '0;
    endtask

    task automatic model_reset();
        cyc = 0; last_busy = -1000; ptr = 0; hs = -1;
        exp_en = 0; exp_perr = 0; exp_addr = '0; exp_data = '0;
        exp_owner = '0; exp_cnt = '0;
    endtask

    // One clock of the main instance: inputs must already be driven.
    task automatic tick();
        int            g;
        logic [NP-1:0] er;
        logic          n_en;
        logic [AW-1:0] na;
        logic [DW-1:0] nd;
        logic [2:0]    no;
        bit            host_ok;
        @(negedge clk);
        // Hosts are eligible once HOLD+2 cycles have elapsed since gen_busy was last seen high.
        host_ok = !gen_busy && !gen_write_en && (cyc - last_busy >= int'(HOLD) + 2);
        g = -1;
        if (host_ok) begin
            for (int k = 0; k < NP; k++) begin
                int p;
                p = (ptr + k) % NP;
                if (g < 0 && req_valid[p]) g = p;
            end
        end
        er = '0;
        if (g >= 0) er[g] = 1'b1;
        chk("req_ready", 64'(req_ready), 64'(er));
        n_en = 0; na = '0; nd = '0; no = '0;
        if (gen_write_en) begin
            n_en = 1; na = gen_write_addr; nd = gen_write_data; no = 3'd0;
        end else if (g >= 0) begin
            n_en = 1; na = pa[g]; nd = pd[g]; no = 3'(g + 1);
        end
        if (gen_write_en && !gen_busy) exp_perr = 1;
        if (gen_busy) last_busy = cyc;
        if (g >= 0) ptr = (g + 1) % NP;
        if (exp_en) exp_cnt = exp_cnt + 32'd1;
        hs = g;
        @(posedge clk);
        #1;
        cyc++;
        exp_en = n_en;
        if (n_en) begin
            exp_addr = na; exp_data = nd; exp_owner = no;
        end
        chk("mem_write_en",   64'(mem_write_en),   64'(exp_en));
        chk("mem_write_addr", 64'(mem_write_addr), 64'(exp_addr));
        chk("mem_write_data", mem_write_data,      exp_data);
        chk("mem_owner",      64'(mem_owner),      64'(exp_owner));
        chk("write_count",    64'(write_count),    64'(exp_cnt));
        chk("proto_err",      64'(proto_err),      64'(exp_perr));
        chk("gen_active",     64'(gen_active),     64'(!(cyc - last_busy >= int'(HOLD) + 2)));
    endtask

    logic [2:0] own_tab [4] = '{3'd1, 3'd2, 3'd1, 3'd2};
    logic       b_busy_t [7] = '{0, 0, 0, 1, 1, 0, 0};
    logic       b_rdy_t  [7] = '{1, 1, 1, 0, 0, 0, 1};

    initial begin
        int            lat;
        logic [AW-1:0] sa;
        logic [DW-1:0] sd;

        // Reset values
        rst = 1'b1;
        idle_inputs();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mem_en",  64'(mem_write_en),   64'(0));
        chk("rst_addr",    64'(mem_write_addr), 64'(0));
        chk("rst_owner",   64'(mem_owner),      64'(0));
        chk("rst_count",   64'(write_count),    64'(0));
        chk("rst_perr",    64'(proto_err),      64'(0));
        chk("rst_gact",    64'(gen_active),     64'(0));
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        model_reset();

        // Two ports streaming: grants alternate, writes every cycle
        new_req(0); new_req(1);
        for (int i = 0; i < 4; i++) begin
            drive_hosts();
            tick();
            chk("rr_owner", 64'(mem_owner), 64'(own_tab[i]));
            if (hs >= 0) new_req(hs);
        end
        pv[0] = 0; pv[1] = 0;
        drive_hosts();
        tick();
        chk("count_after4", 64'(write_count), 64'(4));

        // Lone port1 request
        pv[1] = 1; pa[1] = 18'h00ABC; pd[1] = 64'h1234;
        drive_hosts();
        tick();
        chk("p1_hs",    64'(hs == 1),        64'(1));
        chk("p1_addr",  64'(mem_write_addr), 64'h00ABC);
        chk("p1_data",  mem_write_data,      64'h1234);
        chk("p1_owner", 64'(mem_owner),      64'(2));
        new_req(0); new_req(1);
        drive_hosts();
        tick();
        chk("ptr_wrap_p0", 64'(hs == 0), 64'(1));
        pv[1] = 0;

        // Generator takes over while port0 waits
        new_req(0);
        gen_busy = 1;
        drive_hosts();
        tick();
        chk("gen_stall", 64'(hs >= 0), 64'(0));
        for (int i = 0; i < 3; i++) begin
            gen_write_en   = 1;
            gen_write_addr = 18'h14000 + AW'(i);
            gen_write_data = {$urandom, $urandom};
            tick();
            chk("gen_owner", 64'(mem_owner),      64'(0));
            chk("gen_addr",  64'(mem_write_addr), 64'(18'h14000 + AW'(i)));
        end
        gen_write_en = 0;
        gen_busy     = 0;
        lat = -1;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (hs == 0) begin
                lat = k;
                break;
            end
        end
        chk("hold_latency", 64'(lat), 64'(HOLD + 1));
        pv[0] = 0;
        drive_hosts();

        // Protocol violation: gen write with gen_busy low
        new_req(0);
        drive_hosts();
        gen_write_en   = 1;
        gen_write_addr = AW'($urandom);
        gen_write_data = {$urandom, $urandom};
        tick();
        chk("proto_block", 64'(hs >= 0),    64'(0));
        chk("proto_set",   64'(proto_err),  64'(1));
        gen_write_en = 0;
        tick();
        chk("proto_p0_hs", 64'(hs == 0),    64'(1));
        chk("proto_stick", 64'(proto_err),  64'(1));
        pv[0] = 0;

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(7) == 0) gen_busy = ~gen_busy;
            gen_write_en   = (gen_busy && $urandom_range(1) == 0) || ($urandom_range(60) == 0);
            gen_write_addr = AW'($urandom);
            gen_write_data = {$urandom, $urandom};
            for (int p = 0; p < NP; p++) begin
                if (!pv[p]) begin
                    if ($urandom_range(1) == 0) new_req(p);
                end else if ($urandom_range(24) == 0) begin
                    pv[p] = 0;
                end
            end
            drive_hosts();
            tick();
            if (hs >= 0) pv[hs] = 0;
        end
        gen_busy = 0; gen_write_en = 0;

        // Reset in the middle of a burst with a write registered
        new_req(0); new_req(1);
        drive_hosts();
        repeat (HOLD + 2) tick();
        chk("pre_rst_en", 64'(mem_write_en), 64'(1));
        #2;
        rst = 1'b1;
        #1;
        chk("arst_mem_en", 64'(mem_write_en),   64'(0));
        chk("arst_count",  64'(write_count),    64'(0));
        chk("arst_addr",   64'(mem_write_addr), 64'(0));
        idle_inputs();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        new_req(0); new_req(1);
        drive_hosts();
        tick();
        chk("post_rst_p0", 64'(hs == 0), 64'(1));
        pv[0] = 0; pv[1] = 0;
        drive_hosts();
        tick();

        // Single-port, zero-hold instance
        b_valid = 1'b1;
        for (int i = 0; i < 7; i++) begin
            b_busy = b_busy_t[i];
            sa = AW'($urandom);
            sd = {$urandom, $urandom};
            b_addr = sa;
            b_data = sd;
            #1;
            chk("b_ready", 64'(b_ready), 64'(b_rdy_t[i]));
            tick();
            chk("b_mem_en", 64'(b_men), 64'(b_rdy_t[i]));
            if (b_rdy_t[i]) begin
                chk("b_addr",  64'(b_maddr), 64'(sa));
                chk("b_owner", 64'(b_owner), 64'(1));
            end
        end
        b_valid = '0;
        b_busy  = 0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
